// File: rtl/fp_normalize_shifter.sv
// Floating-point normalisation shifter.
// Takes an unnormalised significand and the leading-one distance reported by
// a leading-one detector. It shifts one bit per cycle until the leading one
// sits at bit 27, adjusting the biased exponent as it goes. Shifted-out bits
// are collected into a sticky flag. Zero, range-error, overflow and underflow
// conditions are flagged on the result.
module fp_normalize_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] mantissa_in,
    input  logic [10:0] exponent_in,
    input  logic [63:0] distance_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] mantissa_out,
    output logic [10:0] exponent_out,
    output logic        sticky_out,
    output logic        zero_out,
    output logic        ovf_out,
    output logic        unf_out,
    output logic        err_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT              stateReg, stateNext;
    logic [63:0]        mantReg, mantNext;
    logic signed [12:0] expReg, expNext;
    logic [5:0]         cntReg, cntNext;
    logic               rightReg, rightNext;
    logic               stickyReg, stickyNext;
    logic               zeroReg, zeroNext;
    logic               errReg, errNext;
    logic               finish;

    // Operand decode. Only the low six bits are needed for the magnitude
    // because any distance that is in range fits in them.
    logic       inZero;
    logic       distErr;
    logic [5:0] distMag;

    assign inZero  = (mantissa_in == 64'd0);
    assign distErr = ($signed(distance_in) > 64'sd36) || ($signed(distance_in) < -64'sd27);
    assign distMag = distance_in[63] ? (~distance_in[5:0] + 6'd1) : distance_in[5:0];

    assign in_ready  = (stateReg == IDLE);
    assign out_valid = (stateReg == DONE);

    // Next-state logic, operand capture and the single-bit shift step.
    always_comb begin
        stateNext  = stateReg;
        mantNext   = mantReg;
        expNext    = expReg;
        cntNext    = cntReg;
        rightNext  = rightReg;
        stickyNext = stickyReg;
        zeroNext   = zeroReg;
        errNext    = errReg;
        finish     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (in_valid) begin
                    mantNext   = mantissa_in;
                    expNext    = {2'b00, exponent_in};
                    cntNext    = distMag;
                    rightNext  = ~distance_in[63];
                    stickyNext = 1'b0;
                    zeroNext   = inZero;
                    errNext    = ~inZero & distErr;
                    if (inZero || distErr || (distMag == 6'd0)) begin
                        stateNext = DONE;
                        finish    = 1'b1;
                    end else begin
                        stateNext = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (rightReg) begin
                    mantNext   = mantReg >> 1;
                    expNext    = expReg + 13'sd1;
                    stickyNext = stickyReg | mantReg[0];
                end else begin
                    mantNext = mantReg << 1;
                    expNext  = expReg - 13'sd1;
                end
                cntNext = cntReg - 6'd1;
                if (cntReg == 6'd1) begin
                    stateNext = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Result formatting applied to the values that will be registered on the
    // finishing edge: zero beats error, error beats exponent range checks.
    logic [63:0] fMant;
    logic [10:0] fExp;
    logic        fSticky;
    logic        fOvf;
    logic        fUnf;

    // Select the final result fields from the post-shift working values.
    always_comb begin
        fMant   = mantNext;
        fExp    = expNext[10:0];
        fSticky = stickyNext;
        fOvf    = 1'b0;
        fUnf    = 1'b0;
        if (zeroNext) begin
            fMant   = 64'd0;
            fExp    = 11'd0;
            fSticky = 1'b0;
        end else if (errNext) begin
            fSticky = 1'b0;
        end else if (expNext > 13'sd2046) begin
            fOvf = 1'b1;
            fExp = 11'h7FF;
        end else if (expNext < 13'sd1) begin
            fUnf = 1'b1;
            fExp = 11'd0;
        end
    end

    // State and working registers; result registers load only when finishing.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            mantReg      <= 64'd0;
            expReg       <= 13'sd0;
            cntReg       <= 6'd0;
            rightReg     <= 1'b0;
            stickyReg    <= 1'b0;
            zeroReg      <= 1'b0;
            errReg       <= 1'b0;
            mantissa_out <= 64'd0;
            exponent_out <= 11'd0;
            sticky_out   <= 1'b0;
            zero_out     <= 1'b0;
            ovf_out      <= 1'b0;
            unf_out      <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            mantReg   <= mantNext;
            expReg    <= expNext;
            cntReg    <= cntNext;
            rightReg  <= rightNext;
            stickyReg <= stickyNext;
            zeroReg   <= zeroNext;
            errReg    <= errNext;
            if (finish) begin
                mantissa_out <= fMant;
                exponent_out <= fExp;
                sticky_out   <= fSticky;
                zero_out     <= zeroNext;
                ovf_out      <= fOvf;
                unf_out      <= fUnf;
                err_out      <= errNext;
            end
        end
    end

endmodule

// File: doc/fp_normalize_shifter.md
FP_NORMALIZE_SHIFTER -- requirements
Module: fp_normalize_shifter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operand valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-006 SHALL have port mantissa_in, input, 64 bits: unnormalised significand; the normalised leading one sits at bit 27.
REQ-007 SHALL have port exponent_in, input, 11 bits: biased exponent.
REQ-008 SHALL have port distance_in, input, 64 bits: two's-complement leading-one distance from the leading-one detector.
- Positive d: leading one at bit 27+d.
- Negative d: leading one at bit 27-|d|.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port mantissa_out, output, 64 bits: normalised significand.
REQ-012 SHALL have port exponent_out, output, 11 bits: adjusted biased exponent.
REQ-013 SHALL have port sticky_out, output, 1 bit: OR of all 1 bits shifted out on the right.
REQ-014 SHALL have port zero_out, output, 1 bit: mantissa_in was all zeros.
REQ-015 SHALL have port ovf_out, output, 1 bit: exponent overflow.
REQ-016 SHALL have port unf_out, output, 1 bit: exponent underflow.
REQ-017 SHALL have port err_out, output, 1 bit: distance_in outside -27..+36.

Function
REQ-018 SHALL implement states IDLE, SHIFT and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE.
REQ-020 SHALL drive out_valid=1 only in DONE.
REQ-021 SHALL, in IDLE on in_valid=1, capture the operand:
- mantissa, exponent (13-bit signed internal), cnt=|d|, dir=sign(d).
- Clear sticky and all flags.
REQ-022 SHALL go from IDLE to DONE directly on capture when cnt=0, mantissa_in=0, or err applies; otherwise it SHALL go to SHIFT.
REQ-023 SHALL, for each cycle in SHIFT:
- d>0: logical right shift by 1, exponent+1, sticky |= bit shifted out.
- d<0: left shift by 1 with zero fill, exponent-1.
- Decrement cnt.
REQ-024 SHALL go from SHIFT to DONE on the cycle cnt reaches 0.
REQ-025 SHALL produce out_valid exactly |d|+1 cycles after the capture edge, with no shift cycles for d=0.
REQ-026 SHALL hold every output stable in DONE while out_ready=0.
REQ-027 SHALL go from DONE to IDLE on the edge where out_ready=1.
REQ-028 SHALL NOT accept a new operand on the DONE-to-IDLE edge (minimum one idle cycle between operands).
REQ-029 SHALL, for mantissa_in=0: set zero_out=1, pass mantissa through as 0, set exponent_out=0, and ignore distance_in.
REQ-030 SHALL, when err applies: set err_out=1 and pass mantissa_in and exponent_in through unmodified.
REQ-031 SHALL, after shifting, set ovf_out=1 if the internal exponent is greater than 2046; exponent_out SHALL then be 2047 (all ones).
REQ-032 SHALL, after shifting, set unf_out=1 if the internal exponent is less than 1; exponent_out SHALL then be 0 and mantissa_out SHALL be the shifted value (no denormal fix-up).
REQ-033 SHALL otherwise set exponent_out to the internal exponent[10:0].
REQ-034 SHALL give zero_out priority over err_out, and err_out priority over ovf_out and unf_out.
REQ-035 SHALL, for a valid non-zero input, produce mantissa_out[27]=1 and mantissa_out[63:28]=0.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, enter IDLE and discard any operand in progress.
REQ-037 SHALL, after reset, hold these values until the next capture:
- in_ready=1, out_valid=0.
- mantissa_out=0, exponent_out=0.
- sticky_out, zero_out, ovf_out, unf_out, err_out all 0.
REQ-038 SHALL give reset priority over in_valid and out_ready in the same cycle.

Verification
REQ-039 Bench SHALL drive mantissa=0x0000_0000_0800_0000, exp=1023, d=0 -> out_valid 1 cycle after capture, mantissa unchanged, exp 1023, all flags 0.
REQ-040 Bench SHALL drive mantissa=0x0000_0000_3000_0001, exp=1000, d=+2 -> 3 cycles to out_valid, mantissa 0x0C00_0000, exp 1002, sticky 1.
REQ-041 Bench SHALL drive mantissa=0x1, exp=100, d=-27 -> 28 cycles to out_valid, mantissa 0x0800_0000, exp 73, sticky 0.
REQ-042 Bench SHALL drive mantissa=0x1, exp=10, d=-27 -> unf_out=1, exp_out 0.
REQ-043 Bench SHALL drive mantissa=1<<63, exp=2040, d=+36 -> ovf_out=1, exp_out 2047.
REQ-044 Bench SHALL:
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable.
- Assert reset mid-SHIFT -> IDLE next cycle with reset values.
- Drive mantissa=0 -> zero_out=1.
- Drive d=+40 -> err_out=1 with pass-through.
